// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, FSM state and flag-index definitions for alu_seq.
package alu_pkg;
   typedef enum logic [2:0] {
      ALU_PASS_B   = 3'b000,
      ALU_MUL      = 3'b001,
      ALU_ADD      = 3'b010,
      ALU_SUBTRACT = 3'b011,
      ALU_AND      = 3'b100,
      ALU_OR       = 3'b101,
      ALU_XOR      = 3'b110,
      ALU_RSVD     = 3'b111
   } alu_op_t;
   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} alu_state_t;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier datapath, one partial product per step.
// Ports: clk, reset_n (async active-low); start loads a/b and the iteration counter;
// step performs one iteration; product is the accumulator after the current
// iteration (low WIDTH bits); last is high while the final iteration is in progress.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] product,
   output logic             last
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [CW-1:0]    cnt;
   assign product = acc + (mplier[0] ? mcand : '0);
   assign last    = cnt == '0;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (start) begin
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
         cnt    <= CW'(WIDTH - 1);
      end else if (step) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
      end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and sticky branch flags.
// Ports: clk, reset_n (async active-low); in_valid/in_ready request port carrying
// cntrl (opcode), A, B, set_flags; out_valid/out_ready result port carrying result,
// negative, zero, overflow, carry_out; flags_q is the sticky {N,Z,V,C} register.
// Define ALU_SEQ_MUL_EN to build the WIDTH-cycle multiplier; otherwise opcode 001
// is treated as reserved.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       cntrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out,
   output logic [3:0]       flags_q
);
   alu_op_t          op;
   alu_state_t       state, state_nxt;
   logic             accept, load, sf_load, sf_mul, mul_done;
   logic             sub, arith, add_c, v_nxt, c_nxt;
   logic [WIDTH-1:0] b_eff, sum, alu_res, res_nxt, mul_prod;
   logic [3:0]       flags_nxt;
   assign op       = alu_op_t'(cntrl);
   assign in_ready = state == S_IDLE && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   // ADD and SUB share one adder: SUB feeds ~B with a carry-in of 1.
   assign sub            = op == ALU_SUBTRACT;
   assign arith          = op == ALU_ADD || sub;
   assign b_eff          = sub ? ~B : B;
   assign {add_c, sum}   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
   always_comb begin
      alu_res = '0;
      case (op)
         ALU_PASS_B:            alu_res = B;
         ALU_ADD, ALU_SUBTRACT: alu_res = sum;
         ALU_AND:               alu_res = A & B;
         ALU_OR:                alu_res = A | B;
         ALU_XOR:               alu_res = A ^ B;
         default:               alu_res = '0;
      endcase
   end
`ifdef ALU_SEQ_MUL_EN
   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (accept && op == ALU_MUL),
      .step   (state == S_MUL),
      .a      (A),
      .b      (B),
      .product(mul_prod),
      .last   (mul_done)
   );
   // set_flags is sampled at accept but only acted on when the product lands.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sf_mul <= 1'b0;
      else if (accept) sf_mul <= set_flags;
`else
   assign mul_prod = '0;
   assign mul_done = 1'b0;
   assign sf_mul   = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= S_IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      sf_load   = set_flags;
      res_nxt   = alu_res;
      v_nxt     = arith && (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      c_nxt     = arith && add_c;
      if (state == S_MUL) begin
         res_nxt = mul_prod;
         v_nxt   = 1'b0;
         c_nxt   = 1'b0;
         sf_load = sf_mul;
         if (mul_done) begin
            load      = 1'b1;
            state_nxt = S_IDLE;
         end
      end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
         if (op == ALU_MUL) state_nxt = S_MUL;
         else load = 1'b1;
`else
         load = 1'b1;
`endif
      end
   end
   always_comb begin
      flags_nxt         = '0;
      flags_nxt[FLAG_N] = res_nxt[WIDTH-1];
      flags_nxt[FLAG_Z] = res_nxt == '0;
      flags_nxt[FLAG_V] = v_nxt;
      flags_nxt[FLAG_C] = c_nxt;
   end
   // A new load on the retiring edge keeps out_valid high with the new result.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         negative  <= 1'b0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
         flags_q   <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         result    <= res_nxt;
         negative  <= flags_nxt[FLAG_N];
         zero      <= flags_nxt[FLAG_Z];
         overflow  <= flags_nxt[FLAG_V];
         carry_out <= flags_nxt[FLAG_C];
         if (sf_load) flags_q <= flags_nxt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
endmodule
